// File: rtl/servo_pkg.sv
// Shared servo link definitions: direction codes used by both the PWM
// generator and decoder, and the decoder FSM state encoding.
package servo_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_MID   = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_sync.sv
// Two-flop synchronizer plus history flop for the servo pulse input.
// Ports: clk_dec, rst_n (sync, active low), pwm_in -> s, rise, fall.
module pwm_sync (
  input  logic clk_dec,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic h;

  always_ff @(posedge clk_dec) begin
    if (!rst_n) begin
      meta <= 1'b0;
      s    <= 1'b0;
      h    <= 1'b0;
    end else begin
      meta <= pwm_in;
      s    <= meta;
      h    <= s;
    end
  end

  assign rise = s & ~h;
  assign fall = ~s & h;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receive decoder: measures high-time, decodes direction, flags
// bad pulses and loss of signal. Ports: clk_dec, rst_n (sync, active low),
// pwm_in -> direc[1:0], valid, err, lost. Optional SERVO_PERIOD_CHECK_EN
// adds rise-to-rise period checking reported on err.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int WIDTH_R = 2,
  parameter int WIDTH_M = 3,
  parameter int WIDTH_L = 4,
  parameter int PERIOD  = 40,
  parameter int TIMEOUT = 60
) (
  input  logic       clk_dec,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [1:0] direc,
  output logic       valid,
  output logic       err,
  output logic       lost
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t TO      = CNT_W'(TIMEOUT);
  localparam cnt_t WR      = CNT_W'(WIDTH_R);
  localparam cnt_t WM      = CNT_W'(WIDTH_M);
  localparam cnt_t WL      = CNT_W'(WIDTH_L);

  function automatic cnt_t sat_inc(input cnt_t x);
    return (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  logic s, rise, fall;

  pwm_sync u_sync (
    .clk_dec (clk_dec),
    .rst_n   (rst_n),
    .pwm_in  (pwm_in),
    .s       (s),
    .rise    (rise),
    .fall    (fall)
  );

  state_t     state, state_n;
  cnt_t       hcnt, hcnt_n;
  cnt_t       lcnt, lcnt_n;
  logic [1:0] direc_n;
  logic       valid_n, err_n, lost_n;

`ifdef SERVO_PERIOD_CHECK_EN
  cnt_t pcnt, pcnt_n;
  logic seen, seen_n;
  logic pend, pend_n;
  logic perr;
`endif

  always_ff @(posedge clk_dec) begin
    if (!rst_n) begin
      state <= S_SYNC;
      hcnt  <= '0;
      lcnt  <= '0;
      direc <= DIR_MID;
      valid <= 1'b0;
      err   <= 1'b0;
      lost  <= 1'b1;
`ifdef SERVO_PERIOD_CHECK_EN
      pcnt  <= '0;
      seen  <= 1'b0;
      pend  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      lcnt  <= lcnt_n;
      direc <= direc_n;
      valid <= valid_n;
      err   <= err_n;
      lost  <= lost_n;
`ifdef SERVO_PERIOD_CHECK_EN
      pcnt  <= pcnt_n;
      seen  <= seen_n;
      pend  <= pend_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    lcnt_n  = lcnt;
    direc_n = direc;
    valid_n = 1'b0;
    err_n   = 1'b0;
    lost_n  = lost;
    unique case (state)
      S_SYNC: begin
        lcnt_n = sat_inc(lcnt);
        if (lcnt == TO) begin
          lost_n  = 1'b1;
          direc_n = DIR_MID;
        end
        // Sync flops read 0 straight out of reset; give them two
        // cycles to carry the real line level before trusting s.
        if (!s && lcnt >= CNT_W'(2))
          state_n = S_LOW;
      end
      S_LOW: begin
        if (rise) begin
          hcnt_n  = CNT_W'(1);
          lcnt_n  = '0;
          state_n = S_HIGH;
        end else begin
          lcnt_n = sat_inc(lcnt);
          if (lcnt == TO) begin
            lost_n  = 1'b1;
            direc_n = DIR_MID;
          end
        end
      end
      S_HIGH: begin
        lcnt_n = '0;
        if (hcnt == TO) begin
          lost_n  = 1'b1;
          direc_n = DIR_MID;
          err_n   = 1'b1;
          state_n = S_SYNC;
        end else if (fall) begin
          state_n = S_LOW;
          unique case (1'b1)
            hcnt == WR: begin
              direc_n = DIR_RIGHT;
              valid_n = 1'b1;
              lost_n  = 1'b0;
            end
            hcnt == WM: begin
              direc_n = DIR_MID;
              valid_n = 1'b1;
              lost_n  = 1'b0;
            end
            hcnt == WL: begin
              direc_n = DIR_LEFT;
              valid_n = 1'b1;
              lost_n  = 1'b0;
            end
            default: err_n = 1'b1;
          endcase
        end else if (s) begin
          hcnt_n = sat_inc(hcnt);
        end
      end
      default: state_n = S_SYNC;
    endcase

`ifdef SERVO_PERIOD_CHECK_EN
    pcnt_n = sat_inc(pcnt);
    seen_n = seen;
    pend_n = 1'b0;
    perr   = 1'b0;
    if (state == S_SYNC) begin
      seen_n = 1'b0;
      pcnt_n = '0;
    end else if (state == S_LOW && rise) begin
      pcnt_n = CNT_W'(1);
      seen_n = 1'b1;
      perr   = seen && (pcnt != CNT_W'(PERIOD));
    end
    // A period fault colliding with a valid strobe slips one cycle.
    if (perr || pend) begin
      if (valid_n) pend_n = 1'b1;
      else         err_n  = 1'b1;
    end
`endif
  end

endmodule
